// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB stage
// and late load returns, buffering loads in a 2-entry FIFO with starvation guard.
module wb_write_arbiter #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_en,
    input  logic [REG_FILE_DEPTH-1:0] wb_dest,
    input  logic [WORD_WIDTH-1:0]     wb_value,
    input  logic                      ld_valid,
    input  logic [REG_FILE_DEPTH-1:0] ld_dest,
    input  logic [WORD_WIDTH-1:0]     ld_data,
    output logic                      ld_ready,
    output logic                      pipe_stall,
    output logic                      rf_we,
    output logic [REG_FILE_DEPTH-1:0] rf_dest,
    output logic [WORD_WIDTH-1:0]     rf_value,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [1:0]                count;
    logic [1:0]                count_nxt;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [CW-1:0]             starve_cnt;
    logic [CW-1:0]             starve_nxt;
    logic [REG_FILE_DEPTH-1:0] fifo_dest [2];
    logic [WORD_WIDTH-1:0]     fifo_data [2];

    logic                      ld_acc;
    logic                      push;
    logic                      pop;
    logic                      inc;
    logic                      clr;
    logic                      sel_wb;
    logic                      sel_ld;
    logic                      wr_any;
    logic [REG_FILE_DEPTH-1:0] wr_dest;
    logic [WORD_WIDTH-1:0]     wr_value;

    // Handshake: a load transfers on any cycle where ld_valid && ld_ready; ld_ready
    // depends only on the registered FIFO count, never on this cycle's pop.
    assign ld_ready   = (count < 2'd2);
    assign ld_acc     = ld_valid && ld_ready;
    assign pipe_stall = (state == FORCE);
    assign state_dbg  = state;

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        inc       = 1'b0;
        clr       = 1'b0;
        sel_wb    = 1'b0;
        sel_ld    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wb_en) begin
                    sel_wb = 1'b1;
                    push   = ld_acc;
                end else if (ld_acc) begin
                    sel_ld = 1'b1;
                end
            end
            PEND: begin
                if (wb_en) begin
                    sel_wb = 1'b1;
                    inc    = 1'b1;
                end else begin
                    pop = 1'b1;
                    clr = 1'b1;
                end
                push = ld_acc;
            end
            FORCE: begin
                pop  = 1'b1;
                clr  = 1'b1;
                push = ld_acc;
            end
            default: ;
        endcase

        count_nxt  = count + {1'b0, push} - {1'b0, pop};
        starve_nxt = clr ? '0 : (inc ? starve_cnt + CW'(1) : starve_cnt);

        case (state)
            IDLE:    state_nxt = push ? PEND : IDLE;
            PEND: begin
                if (count_nxt == 2'd0)
                    state_nxt = IDLE;
                else if (inc && (starve_nxt >= CW'(STARVE_LIMIT)))
                    state_nxt = FORCE;
                else
                    state_nxt = PEND;
            end
            FORCE:   state_nxt = (count_nxt == 2'd0) ? IDLE : PEND;
            default: state_nxt = IDLE;
        endcase

        wr_any   = sel_wb || sel_ld || pop;
        wr_dest  = fifo_dest[rd_ptr];
        wr_value = fifo_data[rd_ptr];
        if (sel_wb) begin
            wr_dest  = wb_dest;
            wr_value = wb_value;
        end else if (sel_ld) begin
            wr_dest  = ld_dest;
            wr_value = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_dest    <= '0;
            rf_value   <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            rf_we <= wr_any;
            if (wr_any) begin
                rf_dest  <= wr_dest;
                rf_value <= wr_value;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest[wr_ptr] <= ld_dest;
            fifo_data[wr_ptr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter, scored against a
// queue-based reference model of the write-port arbitration rules.
module tb_wb_write_arbiter;

    localparam int WW    = 32;
    localparam int DW    = 4;
    localparam int LIMIT = 3;
    localparam int EW    = 1 + DW + WW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_en;
    logic [DW-1:0] wb_dest;
    logic [WW-1:0] wb_value;
    logic          ld_valid;
    logic [DW-1:0] ld_dest;
    logic [WW-1:0] ld_data;
    logic          ld_ready;
    logic          pipe_stall;
    logic          rf_we;
    logic [DW-1:0] rf_dest;
    logic [WW-1:0] rf_value;
    logic [1:0]    state_dbg;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    logic [EW-1:0] exp_q[$];

    // Reference model state: pending loads in arrival order, starvation tally,
    // and whether the next cycle is a forced drain.
    logic [DW-1:0] mq_dest[$];
    logic [WW-1:0] mq_data[$];
    int            m_starve;
    bit            m_force;
    logic          m_we;
    logic [DW-1:0] m_dest;
    logic [WW-1:0] m_val;
    bit            m_wb_taken;
    bit            m_ld_taken;

    wb_write_arbiter #(.WORD_WIDTH(WW), .REG_FILE_DEPTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
        .ld_ready(ld_ready), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_value(rf_value),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_dest.delete();
        mq_data.delete();
        m_starve = 0;
        m_force  = 1'b0;
        m_we     = 1'b0;
        m_dest   = '0;
        m_val    = '0;
    endtask

    task automatic model_step(input logic we, input logic [DW-1:0] wd, input logic [WW-1:0] wv,
                              input logic lv, input logic [DW-1:0] ldd, input logic [WW-1:0] ldv);
        bit acc;
        acc        = lv && (mq_dest.size() < 2);
        m_wb_taken = 1'b0;
        m_ld_taken = acc;
        m_we       = 1'b0;
        if (m_force) begin
            m_we = 1'b1; m_dest = mq_dest.pop_front(); m_val = mq_data.pop_front();
            m_starve = 0;
            m_force  = 1'b0;
            if (acc) begin mq_dest.push_back(ldd); mq_data.push_back(ldv); end
        end else if (mq_dest.size() == 0) begin
            if (we) begin
                m_we = 1'b1; m_dest = wd; m_val = wv; m_wb_taken = 1'b1;
                if (acc) begin mq_dest.push_back(ldd); mq_data.push_back(ldv); end
            end else if (acc) begin
                m_we = 1'b1; m_dest = ldd; m_val = ldv;
            end
        end else begin
            if (we) begin
                m_we = 1'b1; m_dest = wd; m_val = wv; m_wb_taken = 1'b1;
                m_starve++;
                if (m_starve >= LIMIT) m_force = 1'b1;
            end else begin
                m_we = 1'b1; m_dest = mq_dest.pop_front(); m_val = mq_data.pop_front();
                m_starve = 0;
            end
            if (acc) begin mq_dest.push_back(ldd); mq_data.push_back(ldv); end
        end
    endtask

    task automatic drive_cycle(input logic we, input logic [DW-1:0] wd, input logic [WW-1:0] wv,
                               input logic lv, input logic [DW-1:0] ldd, input logic [WW-1:0] ldv);
        @(negedge clk);
        wb_en = we; wb_dest = wd; wb_value = wv;
        ld_valid = lv; ld_dest = ldd; ld_data = ldv;
        check("pipe_stall", 64'(pipe_stall), 64'(m_force));
        check("ld_ready", 64'(ld_ready), 64'(mq_dest.size() < 2));
        model_step(we, wd, wv, lv, ldd, ldv);
        exp_q.push_back({m_we, m_dest, m_val});
    endtask

    task automatic run_random(input int n, input int p_wb, input int p_ld);
        bit            have_wb = 1'b0;
        bit            have_ld = 1'b0;
        logic [DW-1:0] wd = '0;
        logic [WW-1:0] wv = '0;
        logic [DW-1:0] ldd = '0;
        logic [WW-1:0] ldv = '0;
        for (int i = 0; i < n; i++) begin
            if (!have_wb && $urandom_range(99) < p_wb) begin
                have_wb = 1'b1; wd = DW'($urandom); wv = $urandom;
            end
            if (!have_ld && $urandom_range(99) < p_ld) begin
                have_ld = 1'b1; ldd = DW'($urandom); ldv = $urandom;
            end
            drive_cycle(have_wb, wd, wv, have_ld, ldd, ldv);
            if (m_wb_taken) have_wb = 1'b0;
            if (m_ld_taken) have_ld = 1'b0;
        end
    endtask

    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rf_we", 64'(rf_we), 64'(e[EW-1]));
                check("rf_dest", 64'(rf_dest), 64'(e[EW-2 -: DW]));
                check("rf_value", 64'(rf_value), 64'(e[WW-1:0]));
            end
        end
    end

    initial begin : stimulus
        int stall_at;
        logic [DW-1:0] dl[3];
        logic [WW-1:0] vl[3];
        int li;
        logic [WW-1:0] wv;

        rst = 1'b0; wb_en = 1'b0; wb_dest = '0; wb_value = '0;
        ld_valid = 1'b0; ld_dest = '0; ld_data = '0;
        model_reset();
        #1;
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_rf_dest", 64'(rf_dest), 64'd0);
        check("reset_rf_value", 64'(rf_value), 64'd0);
        check("reset_pipe_stall", 64'(pipe_stall), 64'd0);
        check("reset_ld_ready", 64'(ld_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Pipeline write, then direct load bypass from idle.
        drive_cycle(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h11);
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        check("bypass_fifo_empty", 64'(state_dbg), 64'd0);

        // Continuous pipeline pressure with one pending load forces a stall.
        stall_at = -1;
        wv = 32'h1000;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b1, 4'd1, wv, i == 0, 4'd7, 32'h22);
            if (pipe_stall && stall_at < 0) stall_at = i;
            if (m_wb_taken) wv++;
        end
        check("starve_stall_cycle", 64'(stall_at), 64'd4);
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        // Three loads offered back-to-back under pipeline pressure; third waits.
        dl[0] = 4'd9;  vl[0] = 32'hA1;
        dl[1] = 4'd10; vl[1] = 32'hA2;
        dl[2] = 4'd11; vl[2] = 32'hA3;
        li = 0;
        wv = 32'h2000;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(i < 9, 4'd2, wv, li < 3, dl[li % 3], vl[li % 3]);
            if (i == 2) check("full_ld_ready_low", 64'(ld_ready), 64'd0);
            if (m_ld_taken) li++;
            if (m_wb_taken) wv++;
        end
        check("all_loads_taken", 64'(li), 64'd3);

        // One buffered load, then pop and push in the same cycle.
        drive_cycle(1'b1, 4'd4, 32'h3000, 1'b1, 4'd12, 32'hB1);
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd13, 32'hB2);
        check("pop_push_pend", 64'(state_dbg), 64'd1);
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        run_random(1500, 70, 40);
        run_random(800, 95, 80);
        run_random(800, 30, 60);
        repeat (4) drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        // Reset while forced with two loads buffered.
        drive_cycle(1'b1, 4'd6, 32'h4000, 1'b1, 4'd14, 32'hC1);
        drive_cycle(1'b1, 4'd6, 32'h4001, 1'b1, 4'd15, 32'hC2);
        drive_cycle(1'b1, 4'd6, 32'h4002, 1'b0, 4'd0, 32'd0);
        drive_cycle(1'b1, 4'd6, 32'h4003, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check("pre_reset_force", 64'(state_dbg), 64'd2);
        check("pre_reset_full", 64'(ld_ready), 64'd0);
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("async_rf_we", 64'(rf_we), 64'd0);
        check("async_rf_dest", 64'(rf_dest), 64'd0);
        check("async_rf_value", 64'(rf_value), 64'd0);
        check("async_pipe_stall", 64'(pipe_stall), 64'd0);
        check("async_ld_ready", 64'(ld_ready), 64'd1);
        exp_q.delete();
        model_reset();
        wb_en = 1'b0; ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (6) drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        run_random(300, 60, 50);
        repeat (4) drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 32: width of write data.
REQ-002 Parameter REG_FILE_DEPTH, default 4: width of destination register index.
REQ-003 Parameter STARVE_LIMIT, default 3: pipeline-priority cycles tolerated while the load buffer is non-empty.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wb_en  input  1  pipeline WB stage requests a register-file write this cycle.
REQ-007 wb_dest  input  REG_FILE_DEPTH  pipeline write destination.
REQ-008 wb_value  input  WORD_WIDTH  pipeline write data.
REQ-009 ld_valid  input  1  late load-return (memory controller) offers a write.
REQ-010 ld_dest  input  REG_FILE_DEPTH  load-return destination.
REQ-011 ld_data  input  WORD_WIDTH  load-return data.
REQ-012 ld_ready  output  1  arbiter accepts load-return this cycle.
REQ-013 pipe_stall  output  1  pipeline shall hold its WB request and freeze upstream stages.
REQ-014 rf_we  output  1  registered register-file write enable.
REQ-015 rf_dest  output  REG_FILE_DEPTH  registered write destination.
REQ-016 rf_value  output  WORD_WIDTH  registered write data.

Function
REQ-017 Register-file write port is shared: at most one write per cycle, driven from flops; latency from winning request to rf_we is exactly 1 cycle.
REQ-018 Load returns are buffered in a 2-entry FIFO; a load is accepted when ld_valid && ld_ready.
REQ-019 ld_ready = FIFO count < 2, computed from registered count only; a full FIFO does not accept in the same cycle it pops.
REQ-020 FSM states: IDLE (FIFO empty), PEND (FIFO non-empty, pipeline priority), FORCE (FIFO drain forced).
REQ-021 IDLE: wb_en wins if asserted; else an accepted ld_valid bypasses the FIFO and is written directly (not pushed); no write otherwise.
REQ-022 IDLE -> PEND when a load is pushed (ld accepted while wb_en wins).
REQ-023 PEND: wb_en wins and starve counter increments; if wb_en low, FIFO head is popped and written, counter clears.
REQ-024 PEND -> FORCE when counter reaches STARVE_LIMIT; PEND -> IDLE when FIFO becomes empty with no push.
REQ-025 FORCE: pipe_stall = 1 (combinational from state), FIFO head popped and written regardless of wb_en, counter clears; next state PEND if FIFO still non-empty after pop/push, else IDLE.
REQ-026 pipe_stall = 0 in IDLE and PEND; while stalled, wb_en/wb_dest/wb_value are held by the pipeline and serviced on a later cycle.
REQ-027 Simultaneous push and pop in PEND/FORCE: both occur, count unchanged, FIFO order preserved (oldest load written first).
REQ-028 FIFO pointers are 1-bit and wrap 1 -> 0; count is 2-bit, never exceeds 2.
REQ-029 Destination ordering hazards between pipeline and pending loads are resolved upstream; the arbiter does not compare destinations.
REQ-030 rf_we = 0 on any cycle following one with no winner; rf_dest/rf_value hold last written values when rf_we = 0.

Reset
REQ-031 On rst low, immediately: state IDLE, FIFO count 0, pointers 0, counter 0, rf_we 0, rf_dest 0, rf_value 0, pipe_stall 0, ld_ready 1.
REQ-032 Reset mid-operation discards all buffered loads; no write issues in the cycle after rst deasserts unless a request is present on that edge.

Verification
REQ-033 wb_en=1, wb_dest=5, wb_value=0xDEADBEEF, no load -> next cycle rf_we=1, rf_dest=5, rf_value=0xDEADBEEF.
REQ-034 IDLE, wb_en=0, ld_valid=1, ld_dest=3, ld_data=0x11 -> next cycle rf_we=1, rf_dest=3, rf_value=0x11, FIFO stays empty.
REQ-035 wb_en=1 continuously, one load (dest 7, 0x22) pushed -> pipeline writes 3 cycles, then pipe_stall=1 one cycle, next rf write dest 7 value 0x22, then held pipeline write completes.
REQ-036 wb_en=1, two loads pushed back-to-back -> ld_ready=0 with count 2; third ld_valid not accepted until a pop; writes occur in push order.
REQ-037 FIFO holds one entry, in PEND with wb_en=0 and ld_valid=1 -> pop and push same cycle, count stays 1, older entry written first.
REQ-038 rst pulled low while count=2 and state FORCE -> outputs at reset values immediately, ld_ready=1, no buffered load ever written after release.
